// File: rtl/npc_gate_monitor_pkg.sv
// Shared types and constants for the 3L-NPC gate monitor.
// Gate patterns, pattern classes, monitor states and fault codes.
package PKG_decoder_3lxnpc;

  localparam int TDELAY_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_P,
    ST_Z,
    ST_N,
    ST_DP,
    ST_DN,
    ST_FAULT
  } _gmon_state_t;

  typedef enum logic [2:0] {
    PAT_P,
    PAT_Z,
    PAT_N,
    PAT_DP,
    PAT_DN,
    PAT_ILL
  } _gpat_t;

  localparam logic [5:0] GP_P  = 6'b110000;
  localparam logic [5:0] GP_Z  = 6'b011000;
  localparam logic [5:0] GP_N  = 6'b001100;
  localparam logic [5:0] GP_DP = 6'b010000;
  localparam logic [5:0] GP_DN = 6'b001000;

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_ILL_PAT     = 3'd1;
  localparam logic [2:0] FC_ILL_SEQ     = 3'd2;
  localparam logic [2:0] FC_DEAD_SHORT  = 3'd3;
  localparam logic [2:0] FC_DWELL_SHORT = 3'd4;
  localparam logic [2:0] FC_DEAD_TO     = 3'd5;

  function automatic _gmon_state_t pat2st(input _gpat_t p);
    _gmon_state_t s;
    s = ST_FAULT;
    case (p)
      PAT_P:   s = ST_P;
      PAT_Z:   s = ST_Z;
      PAT_N:   s = ST_N;
      PAT_DP:  s = ST_DP;
      PAT_DN:  s = ST_DN;
      default: s = ST_FAULT;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] pat_lev(input _gpat_t p);
    logic [1:0] l;
    l = 2'b00;
    if (p == PAT_P) l = 2'b01;
    if (p == PAT_N) l = 2'b10;
    return l;
  endfunction

  // Dead patterns sit strictly between their two neighbours,
  // so either neighbour is a legal exit.
  function automatic logic gmon_legal(
    input _gmon_state_t s,
    input _gpat_t       p
  );
    logic ok;
    ok = 1'b0;
    case (s)
      ST_P:    ok = (p == PAT_DP);
      ST_Z:    ok = (p == PAT_DP) || (p == PAT_DN);
      ST_N:    ok = (p == PAT_DN);
      ST_DP:   ok = (p == PAT_P) || (p == PAT_Z);
      ST_DN:   ok = (p == PAT_N) || (p == PAT_Z);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/npc_gate_monitor_classify.sv
// Combinational gate-vector classifier for one 3L-NPC leg.
// Anything other than the five exact patterns is illegal.
module npc_gate_classify
  import PKG_decoder_3lxnpc::*;
(
  input  logic [5:0] i_s,
  output _gpat_t     o_pat
);

  always_comb begin
    o_pat = PAT_ILL;
    unique case (1'b1)
      (i_s == GP_P):  o_pat = PAT_P;
      (i_s == GP_Z):  o_pat = PAT_Z;
      (i_s == GP_N):  o_pat = PAT_N;
      (i_s == GP_DP): o_pat = PAT_DP;
      (i_s == GP_DN): o_pat = PAT_DN;
      default:        o_pat = PAT_ILL;
    endcase
  end

endmodule

// File: rtl/npc_gate_monitor.sv
// 3L-NPC gate monitor: level decode, commutation checks,
// dead-time measurement and sticky first-fault capture.
module npc_gate_monitor
  import PKG_decoder_3lxnpc::*;
#(
  parameter int CNT_W = TDELAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       S_in,
  input  logic [CNT_W-1:0] t_dead_min,
  input  logic [CNT_W-1:0] t_dead_max,
  input  logic [CNT_W-1:0] t_dwell_min,
  input  logic             clr_fault,
  output logic [1:0]       v_lev_out,
  output logic             v_valid,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] dt_meas,
  output logic             dt_valid
);

  logic [5:0]       r_s_q;
  _gmon_state_t     r_state;
  logic [CNT_W-1:0] r_dead;
  logic [CNT_W-1:0] r_dwell;
  logic [1:0]       r_lev;
  logic             r_valid;
  logic             r_fault;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_dt;
  logic             r_dtv;

  _gpat_t           w_pat;
  _gmon_state_t     w_st_nxt;
  logic [CNT_W-1:0] w_dead_nxt;
  logic [CNT_W-1:0] w_dwell_nxt;
  logic [1:0]       w_lev_nxt;
  logic             w_val_nxt;
  logic             w_flt_nxt;
  logic [2:0]       w_code_nxt;
  logic [CNT_W-1:0] w_dt_nxt;
  logic             w_dtv_nxt;
  logic [2:0]       w_code;
  logic             w_is_dead;
  logic             w_to_dead;
  logic             w_same;
  logic             w_stable;
  logic [CNT_W-1:0] w_dead_inc;
  logic [CNT_W-1:0] w_dwell_inc;

  npc_gate_classify u_cls (
    .i_s   (r_s_q),
    .o_pat (w_pat)
  );

  assign w_is_dead   = (r_state == ST_DP) || (r_state == ST_DN);
  assign w_to_dead   = (w_pat == PAT_DP) || (w_pat == PAT_DN);
  assign w_stable    = (w_pat == PAT_P) || (w_pat == PAT_Z)
                    || (w_pat == PAT_N);
  assign w_same      = (pat2st(w_pat) == r_state);
  assign w_dead_inc  = (&r_dead) ? r_dead : r_dead + CNT_W'(1);
  assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q   <= GP_Z;
      r_state <= ST_Z;
      r_dead  <= '0;
      r_dwell <= '1;
      r_lev   <= 2'b00;
      r_valid <= 1'b1;
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
      r_dt    <= '0;
      r_dtv   <= 1'b0;
    end else begin
      r_s_q   <= S_in;
      r_state <= w_st_nxt;
      r_dead  <= w_dead_nxt;
      r_dwell <= w_dwell_nxt;
      r_lev   <= w_lev_nxt;
      r_valid <= w_val_nxt;
      r_fault <= w_flt_nxt;
      r_code  <= w_code_nxt;
      r_dt    <= w_dt_nxt;
      r_dtv   <= w_dtv_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_state;
    w_dead_nxt  = r_dead;
    w_dwell_nxt = r_dwell;
    w_lev_nxt   = r_lev;
    w_val_nxt   = r_valid;
    w_flt_nxt   = r_fault;
    w_code_nxt  = r_code;
    w_dt_nxt    = r_dt;
    w_dtv_nxt   = 1'b0;
    w_code      = FC_NONE;

    if (r_state == ST_FAULT) begin
      if (clr_fault && w_stable) begin
        w_st_nxt    = pat2st(w_pat);
        w_flt_nxt   = 1'b0;
        w_code_nxt  = FC_NONE;
        w_dwell_nxt = '1;
        w_lev_nxt   = pat_lev(w_pat);
        w_val_nxt   = 1'b1;
      end
    end else if (w_same) begin
      if (w_is_dead) begin
        w_dead_nxt = w_dead_inc;
        if ((t_dead_max != '0) && (w_dead_inc >= t_dead_max))
          w_code = FC_DEAD_TO;
      end else begin
        w_dwell_nxt = w_dwell_inc;
      end
    end else begin
      if (w_is_dead) begin
        w_dt_nxt  = r_dead;
        w_dtv_nxt = 1'b1;
      end
      // Checks in descending priority; only the winner is latched.
      if (w_pat == PAT_ILL)
        w_code = FC_ILL_PAT;
      else if (!gmon_legal(r_state, w_pat))
        w_code = FC_ILL_SEQ;
      else if (w_to_dead && (t_dead_max == CNT_W'(1)))
        w_code = FC_DEAD_TO;
      else if (w_is_dead && (t_dead_min != '0)
               && (r_dead < t_dead_min))
        w_code = FC_DEAD_SHORT;
      else if (!w_is_dead && (t_dwell_min != '0)
               && (r_dwell < t_dwell_min))
        w_code = FC_DWELL_SHORT;

      if (w_code == FC_NONE) begin
        w_st_nxt = pat2st(w_pat);
        if (w_to_dead) begin
          w_dead_nxt = CNT_W'(1);
          w_val_nxt  = 1'b0;
        end else begin
          w_dwell_nxt = CNT_W'(1);
          w_lev_nxt   = pat_lev(w_pat);
          w_val_nxt   = 1'b1;
        end
      end
    end

    if (w_code != FC_NONE) begin
      w_st_nxt   = ST_FAULT;
      w_flt_nxt  = 1'b1;
      w_code_nxt = w_code;
      w_val_nxt  = 1'b0;
    end
  end

  assign v_lev_out  = r_lev;
  assign v_valid    = r_valid;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign dt_meas    = r_dt;
  assign dt_valid   = r_dtv;

endmodule
